multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 25 ++
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control path.
// Contents: controller state enum, opcode constants, and the alu_control,
// alu_src_a/b and result_src encodings used by the controller and ALU decoder.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        TRAP
    } state_t;

    // Opcodes (instruction bits 6:0)
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // alu_control encodings
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // alu_src_a encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // result_src encodings
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from opcode/funct3/funct7b5.
// Ports: op, funct3, funct7b5 in; alu_control out. Purely combinational.
// Latency 0; no flow control.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            // I-type has no subi, so funct7b5 only selects sub for R-type
            3'b000:  alu_control = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control = ALU_SLT;
            3'b110:  alu_control = ALU_OR;
            3'b111:  alu_control = ALU_AND;
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and traps unknown opcodes.
// Latency: R/I 4, load 5, store 4, beq 3, jal 4 cycles plus memory wait states; mem_ready stalls FETCH/MEMREAD/MEMWRITE.
// Ports: clk, rst_n (async low, also gates all outputs to 0); instruction fields and zero/mem_ready in; datapath controls out.
// Optional: define RETIRE_CNT_EN to add a 32-bit wrapping retired-instruction counter output.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        adr_src,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [2:0]  alu_control,
    output logic        illegal
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    state_t     state, state_n;
    logic [2:0] alu_dec;

    logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c;
    logic       adr_src_c, reg_write_c, illegal_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;
    logic [2:0] alu_control_c;

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_n;
    end

    always_comb begin
        state_n       = state;
        mem_req_c     = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        adr_src_c     = 1'b0;
        reg_write_c   = 1'b0;
        illegal_c     = 1'b0;
        alu_src_a_c   = SRCA_PC;
        alu_src_b_c   = SRCB_RS2;
        result_src_c  = RES_ALUOUT;
        alu_control_c = ALU_ADD;
        case (state)
            FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_n    = DECODE;
                end
            end
            DECODE: begin
                // Precompute branch target OldPC + imm while decoding
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_n = MEMADR;
                    OP_RTYPE:          state_n = EXECR;
                    OP_ITYPE:          state_n = EXECI;
                    OP_BEQ:            state_n = BEQ;
                    OP_JAL:            state_n = JAL;
                    default:           state_n = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_n     = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) state_n = MEMWB;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src_c   = 1'b1;
                if (mem_ready) state_n = FETCH;
            end
            MEMWB: begin
                result_src_c = RES_RDATA;
                reg_write_c  = 1'b1;
                state_n      = FETCH;
            end
            EXECR: begin
                alu_src_a_c   = SRCA_RS1;
                alu_src_b_c   = SRCB_RS2;
                alu_control_c = alu_dec;
                state_n       = ALUWB;
            end
            EXECI: begin
                alu_src_a_c   = SRCA_RS1;
                alu_src_b_c   = SRCB_IMM;
                alu_control_c = alu_dec;
                state_n       = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                state_n     = FETCH;
            end
            BEQ: begin
                alu_src_a_c   = SRCA_RS1;
                alu_src_b_c   = SRCB_RS2;
                alu_control_c = ALU_SUB;
                // ALUOut holds the target computed in DECODE
                pc_write_c    = zero;
                state_n       = FETCH;
            end
            JAL: begin
                // OldPC + 4 is the link value written back in ALUWB
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_FOUR;
                pc_write_c  = 1'b1;
                state_n     = ALUWB;
            end
            TRAP: begin
                illegal_c = 1'b1;
            end
            default: state_n = FETCH;
        endcase
    end

    // Reset gates every output combinationally so an in-flight write drops at once
    assign mem_req     = rst_n & mem_req_c;
    assign mem_write   = rst_n & mem_write_c;
    assign ir_write    = rst_n & ir_write_c;
    assign pc_write    = rst_n & pc_write_c;
    assign adr_src     = rst_n & adr_src_c;
    assign reg_write   = rst_n & reg_write_c;
    assign illegal     = rst_n & illegal_c;
    assign alu_src_a   = rst_n ? alu_src_a_c   : 2'b00;
    assign alu_src_b   = rst_n ? alu_src_b_c   : 2'b00;
    assign result_src  = rst_n ? result_src_c  : 2'b00;
    assign alu_control = rst_n ? alu_control_c : 3'b000;

`ifdef RETIRE_CNT_EN
    logic [31:0] retired_q;
    logic        retire;

    // Every completing instruction is the only path back into FETCH
    assign retire = (state_n == FETCH) && (state != FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      retired_q <= 32'd0;
        else if (retire) retired_q <= retired_q + 32'd1;
    end

    assign retired = retired_q;
`endif

endmodule
